// File: rtl/cache_hier_ctrl.sv
// N-level cache hierarchy controller: probes levels in order, promotes hits into
// faster levels, falls back to main memory, and keeps saturating AMAT counters.
module cache_hier_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int LEVELS = 2,
    parameter int CNT_W  = 32,
    parameter logic [8*(LEVELS+1)-1:0] LAT = {8'd100, 8'd10, 8'd1}
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic [LEVELS-1:0]        lvl_lookup,
    output logic [ADDR_W-1:0]        lvl_addr,
    input  logic [LEVELS-1:0]        lvl_hit,
    input  logic [LEVELS*DATA_W-1:0] lvl_data,
    input  logic [DATA_W-1:0]        mem_data,
    output logic [LEVELS-1:0]        fill_en,
    output logic [DATA_W-1:0]        fill_data,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_W-1:0]        resp_data,
    output logic [2:0]               resp_level,
    input  logic                     clear_counters,
    input  logic [1:0]               cnt_sel,
    output logic [CNT_W-1:0]         cnt_hit,
    output logic [CNT_W-1:0]         cnt_miss,
    output logic [CNT_W-1:0]         access_count,
    output logic [CNT_W+7:0]         lat_sum
);

    typedef enum logic [2:0] {IDLE, PROBE, CHECK, MEM, FILL, RESP} state_t;

    state_t              state;
    logic [LEVELS-1:0]   cur;        // one-hot level currently being probed
    logic [LEVELS-1:0]   fill_mask;
    logic [2:0]          level_q;
    logic [DATA_W-1:0]   data_q;
    logic [CNT_W-1:0]    hit_cnt  [LEVELS];
    logic [CNT_W-1:0]    miss_cnt [LEVELS];

    logic                hit_now;
    logic [DATA_W-1:0]   sel_data;
    logic [2:0]          cur_num;
    logic                resp_entry;
    logic [2:0]          entry_level;
    logic [10:0]         lat_add;
    logic [CNT_W+8:0]    lat_ext;

    always_comb begin
        hit_now  = |(lvl_hit & cur);
        sel_data = '0;
        cur_num  = '0;
        for (int j = 0; j < LEVELS; j++) begin
            if (cur[j]) begin
                sel_data = lvl_data[j*DATA_W +: DATA_W];
                cur_num  = 3'(j);
            end
        end
        // Only an L1 hit skips FILL; every other path enters RESP from FILL.
        resp_entry  = (state == CHECK && hit_now && cur[0]) || (state == FILL);
        entry_level = (state == FILL) ? level_q : 3'd0;
        lat_add     = '0;
        for (int j = 0; j <= LEVELS; j++) begin
            if (3'(j) <= entry_level) lat_add = lat_add + 11'(LAT[8*j +: 8]);
        end
        lat_ext = {1'b0, lat_sum} + (CNT_W+9)'(lat_add);
    end

    always_comb begin
        cnt_hit  = '0;
        cnt_miss = '0;
        for (int j = 0; j < LEVELS; j++) begin
            if (cnt_sel == 2'(j)) begin
                cnt_hit  = hit_cnt[j];
                cnt_miss = miss_cnt[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cur          <= '0;
            fill_mask    <= '0;
            level_q      <= '0;
            data_q       <= '0;
            req_ready    <= 1'b0;
            lvl_lookup   <= '0;
            lvl_addr     <= '0;
            fill_en      <= '0;
            fill_data    <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_level   <= '0;
            access_count <= '0;
            lat_sum      <= '0;
            for (int j = 0; j < LEVELS; j++) begin
                hit_cnt[j]  <= '0;
                miss_cnt[j] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lvl_addr  <= req_addr;
                        cur       <= LEVELS'(1);
                        req_ready <= 1'b0;
                        state     <= PROBE;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                PROBE: begin
                    lvl_lookup <= cur;
                    state      <= CHECK;
                end
                CHECK: begin
                    lvl_lookup <= '0;
                    if (hit_now) begin
                        data_q    <= sel_data;
                        level_q   <= cur_num;
                        fill_mask <= cur - LEVELS'(1);  // every level faster than the hit
                        state     <= cur[0] ? RESP : FILL;
                    end else if (cur[LEVELS-1]) begin
                        state <= MEM;
                    end else begin
                        cur   <= cur << 1;
                        state <= PROBE;
                    end
                end
                MEM: begin
                    data_q    <= mem_data;
                    level_q   <= 3'(LEVELS);
                    fill_mask <= '1;
                    state     <= FILL;
                end
                FILL: begin
                    fill_en   <= fill_mask;
                    fill_data <= data_q;
                    state     <= RESP;
                end
                RESP: begin
                    fill_en <= '0;
                    if (resp_valid && resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_data  <= data_q;
                        resp_level <= level_q;
                    end
                end
                default: state <= IDLE;
            endcase

            for (int j = 0; j < LEVELS; j++) begin
                if (clear_counters) begin
                    hit_cnt[j]  <= '0;
                    miss_cnt[j] <= '0;
                end else if (state == CHECK && cur[j]) begin
                    if (hit_now && hit_cnt[j] != '1)        hit_cnt[j]  <= hit_cnt[j] + 1'b1;
                    else if (!hit_now && miss_cnt[j] != '1) miss_cnt[j] <= miss_cnt[j] + 1'b1;
                end
            end

            if (clear_counters) begin
                access_count <= '0;
                lat_sum      <= '0;
            end else if (resp_entry) begin
                if (access_count != '1) access_count <= access_count + 1'b1;
                lat_sum <= lat_ext[CNT_W+8] ? '1 : lat_ext[CNT_W+7:0];
            end
        end
    end

endmodule

// File: tb/tb_cache_hier_ctrl.sv
// Directed bench for cache_hier_ctrl: two levels, 4-bit counters so that
// saturation is reachable in a handful of accesses.
module tb_cache_hier_ctrl;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int LEVELS = 2;
    localparam int CNT_W  = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     req_valid = 1'b0;
    logic                     req_ready;
    logic [ADDR_W-1:0]        req_addr = '0;
    logic [LEVELS-1:0]        lvl_lookup;
    logic [ADDR_W-1:0]        lvl_addr;
    logic [LEVELS-1:0]        lvl_hit = '0;
    logic [LEVELS*DATA_W-1:0] lvl_data = '0;
    logic [DATA_W-1:0]        mem_data = '0;
    logic [LEVELS-1:0]        fill_en;
    logic [DATA_W-1:0]        fill_data;
    logic                     resp_valid;
    logic                     resp_ready = 1'b0;
    logic [DATA_W-1:0]        resp_data;
    logic [2:0]               resp_level;
    logic                     clear_counters = 1'b0;
    logic [1:0]               cnt_sel = '0;
    logic [CNT_W-1:0]         cnt_hit, cnt_miss, access_count;
    logic [CNT_W+7:0]         lat_sum;

    int n_cmp = 0;
    int n_fail = 0;

    // results of the last run_access
    int          r_lat;
    logic [3:0]  r_look;
    int          r_nlook;
    logic [1:0]  r_fill;
    logic [31:0] r_fdata;
    logic [31:0] r_data;
    logic [2:0]  r_level;
    logic        r_overlap;
    logic        r_stable;
    logic [10:0] r_addr;

    cache_hier_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEVELS(LEVELS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .lvl_lookup(lvl_lookup), .lvl_addr(lvl_addr),
        .lvl_hit(lvl_hit), .lvl_data(lvl_data), .mem_data(mem_data),
        .fill_en(fill_en), .fill_data(fill_data), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .resp_level(resp_level),
        .clear_counters(clear_counters), .cnt_sel(cnt_sel), .cnt_hit(cnt_hit),
        .cnt_miss(cnt_miss), .access_count(access_count), .lat_sum(lat_sum)
    );

    always #5 clk = ~clk;

    task automatic pulse_clear();
        clear_counters = 1'b1;
        @(posedge clk); #1;
        clear_counters = 1'b0;
    endtask

    // One complete transaction. clear_at=c holds clear_counters high during the
    // cycle that ends at accept edge + c (0 = never).
    task automatic run_access(input logic [10:0] addr, input logic [1:0] hit,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] mem, input int hold, input int clear_at);
        int w;
        lvl_hit = hit; lvl_data = {d1, d0}; mem_data = mem; req_addr = addr;
        r_look = '0; r_nlook = 0; r_fill = '0; r_fdata = '0; r_overlap = 1'b0;
        r_stable = 1'b1; r_lat = -1; r_addr = '0;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        clear_counters = (clear_at == 1);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            clear_counters = (n == clear_at - 1);
            if (n == 1) r_addr = lvl_addr;
            if (lvl_lookup != '0 && r_nlook < 2) begin
                r_look[2*r_nlook +: 2] = lvl_lookup;
                r_nlook++;
            end
            if (fill_en != '0) begin r_fill = r_fill | fill_en; r_fdata = fill_data; end
            if ((lvl_lookup & fill_en) != '0 || (lvl_lookup != '0 && fill_en != '0)) r_overlap = 1'b1;
            if (resp_valid === 1'b1) begin r_lat = n; break; end
        end
        clear_counters = 1'b0;
        r_data = resp_data; r_level = resp_level;
        if (r_lat < 0) return;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_data !== r_data || resp_level !== r_level
                || req_ready !== 1'b0) r_stable = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %0b want 0", req_ready); end
        n_cmp++; if ({resp_valid, lvl_lookup, fill_en} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want 0", {resp_valid, lvl_lookup, fill_en}); end
        n_cmp++; if (access_count !== 4'd0 || lat_sum !== 12'd0 || cnt_hit !== 4'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", access_count, lat_sum, cnt_hit); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %0b want 1", req_ready); end
    endtask

    task automatic test_l1_hit();
        pulse_clear();
        run_access(11'h012, 2'b01, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0);
        n_cmp++; if (r_lat !== 3) begin n_fail++; $display("FAIL l1_latency: got %0d want 3", r_lat); end
        n_cmp++; if (r_addr !== 11'h012) begin n_fail++; $display("FAIL l1_lvl_addr: got %h want 012", r_addr); end
        n_cmp++; if (r_data !== 32'hDEADBEEF || r_level !== 3'd0) begin n_fail++; $display("FAIL l1_resp: got %h/%0d want deadbeef/0", r_data, r_level); end
        n_cmp++; if (r_fill !== 2'b00 || r_nlook !== 1 || r_look[1:0] !== 2'b01) begin n_fail++; $display("FAIL l1_strobes: got fill %b look %b n %0d want 00/01/1", r_fill, r_look, r_nlook); end
        cnt_sel = 2'd0; #1;
        n_cmp++; if (cnt_hit !== 4'd1 || cnt_miss !== 4'd0) begin n_fail++; $display("FAIL l1_counts: got hit %0d miss %0d want 1/0", cnt_hit, cnt_miss); end
        n_cmp++; if (lat_sum !== 12'd1 || access_count !== 4'd1) begin n_fail++; $display("FAIL l1_lat: got %0d/%0d want 1/1", lat_sum, access_count); end
        n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL l1_idle_after: got rdy %b vld %b want 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_l2_hit();
        pulse_clear();
        run_access(11'h155, 2'b10, 32'h11111111, 32'h12345678, 32'h0, 0, 0);
        n_cmp++; if (r_lat !== 6) begin n_fail++; $display("FAIL l2_latency: got %0d want 6", r_lat); end
        n_cmp++; if (r_nlook !== 2 || r_look !== 4'b1001) begin n_fail++; $display("FAIL l2_lookup_seq: got %b n %0d want 1001/2", r_look, r_nlook); end
        n_cmp++; if (r_fill !== 2'b01 || r_fdata !== 32'h12345678) begin n_fail++; $display("FAIL l2_fill: got %b %h want 01 12345678", r_fill, r_fdata); end
        n_cmp++; if (r_data !== 32'h12345678 || r_level !== 3'd1) begin n_fail++; $display("FAIL l2_resp: got %h/%0d want 12345678/1", r_data, r_level); end
        n_cmp++; if (r_overlap !== 1'b0) begin n_fail++; $display("FAIL l2_overlap: got %b want 0", r_overlap); end
        cnt_sel = 2'd0; #1;
        n_cmp++; if (cnt_miss !== 4'd1 || cnt_hit !== 4'd0) begin n_fail++; $display("FAIL l2_l1counts: got hit %0d miss %0d want 0/1", cnt_hit, cnt_miss); end
        cnt_sel = 2'd1; #1;
        n_cmp++; if (cnt_hit !== 4'd1 || cnt_miss !== 4'd0) begin n_fail++; $display("FAIL l2_l2counts: got hit %0d miss %0d want 1/0", cnt_hit, cnt_miss); end
        n_cmp++; if (lat_sum !== 12'd11) begin n_fail++; $display("FAIL l2_lat_sum: got %0d want 11", lat_sum); end
    endtask

    task automatic test_all_miss();
        pulse_clear();
        run_access(11'h7FF, 2'b00, 32'h1, 32'h2, 32'hCAFEF00D, 0, 0);
        n_cmp++; if (r_lat !== 7) begin n_fail++; $display("FAIL mem_latency: got %0d want 7", r_lat); end
        n_cmp++; if (r_fill !== 2'b11 || r_fdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mem_fill: got %b %h want 11 cafef00d", r_fill, r_fdata); end
        n_cmp++; if (r_data !== 32'hCAFEF00D || r_level !== 3'd2) begin n_fail++; $display("FAIL mem_resp: got %h/%0d want cafef00d/2", r_data, r_level); end
        cnt_sel = 2'd0; #1;
        n_cmp++; if (cnt_miss !== 4'd1) begin n_fail++; $display("FAIL mem_miss0: got %0d want 1", cnt_miss); end
        cnt_sel = 2'd1; #1;
        n_cmp++; if (cnt_miss !== 4'd1 || cnt_hit !== 4'd0) begin n_fail++; $display("FAIL mem_miss1: got miss %0d hit %0d want 1/0", cnt_miss, cnt_hit); end
        n_cmp++; if (lat_sum !== 12'd111) begin n_fail++; $display("FAIL mem_lat_sum: got %0d want 111", lat_sum); end
        cnt_sel = 2'd2; #1;
        n_cmp++; if (cnt_hit !== 4'd0 || cnt_miss !== 4'd0) begin n_fail++; $display("FAIL sel_out_of_range: got %0d/%0d want 0/0", cnt_hit, cnt_miss); end
    endtask

    task automatic test_backpressure();
        pulse_clear();
        run_access(11'h0A0, 2'b01, 32'hA5A5A5A5, 32'h0, 32'h0, 5, 0);
        n_cmp++; if (r_stable !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %b want 1", r_stable); end
        n_cmp++; if (r_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bp_data: got %h want a5a5a5a5", r_data); end
        n_cmp++; if (access_count !== 4'd1) begin n_fail++; $display("FAIL bp_access_count: got %0d want 1", access_count); end
        n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got vld %b rdy %b want 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_reset_in_fill();
        logic seen;
        lvl_hit = 2'b10; lvl_data = {32'h0BADF00D, 32'h0}; mem_data = '0;
        req_valid = 1'b1;
        @(posedge clk); #1;                 // accept edge E0
        req_valid = 1'b0;
        repeat (4) @(posedge clk);          // E4: CHECK(1) hit, now in FILL
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({fill_en, resp_valid, req_ready} !== 4'b0) begin n_fail++; $display("FAIL rstfill_outputs: got %b want 0000", {fill_en, resp_valid, req_ready}); end
        cnt_sel = 2'd1; #1;
        n_cmp++; if (cnt_hit !== 4'd0 || access_count !== 4'd0) begin n_fail++; $display("FAIL rstfill_hit1: got %0d/%0d want 0/0", cnt_hit, access_count); end
        cnt_sel = 2'd0; #1;
        n_cmp++; if (cnt_miss !== 4'd0 || lat_sum !== 12'd0) begin n_fail++; $display("FAIL rstfill_miss0: got %0d/%0d want 0/0", cnt_miss, lat_sum); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstfill_ready: got %b want 1", req_ready); end
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b0 || fill_en !== 2'b00) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstfill_no_resp: got %b want 0", seen); end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_h;
        pulse_clear();
        for (int i = 0; i < 14; i++) run_access(11'(i), 2'b01, 32'(i), 32'h0, 32'h0, 0, 0);
        cnt_sel = 2'd0; #1;
        n_cmp++; if (cnt_hit !== 4'hE) begin n_fail++; $display("FAIL sat_pre: got %0d want 14", cnt_hit); end
        for (int i = 0; i < 3; i++) begin
            run_access(11'h100, 2'b01, 32'h5, 32'h0, 32'h0, 0, 0);
            exp_h = (i == 0) ? 4'hF : 4'hF;
            #1;
            n_cmp++; if (cnt_hit !== exp_h || access_count !== 4'hF) begin n_fail++; $display("FAIL sat_hit%0d: got %0d/%0d want 15/15", i, cnt_hit, access_count); end
        end
        n_cmp++; if (lat_sum !== 12'd17) begin n_fail++; $display("FAIL sat_lat_sum: got %0d want 17", lat_sum); end
    endtask

    task automatic test_clear_coincide();
        pulse_clear();
        run_access(11'h020, 2'b01, 32'h77, 32'h0, 32'h0, 0, 2);   // clear on the hit/RESP-entry edge
        cnt_sel = 2'd0; #1;
        n_cmp++; if (cnt_hit !== 4'd0 || access_count !== 4'd0 || lat_sum !== 12'd0) begin n_fail++; $display("FAIL clr_l1: got %0d/%0d/%0d want 0/0/0", cnt_hit, access_count, lat_sum); end
        run_access(11'h021, 2'b10, 32'h0, 32'h88, 32'h0, 0, 2);   // clear on the L1-miss edge
        cnt_sel = 2'd0; #1;
        n_cmp++; if (cnt_miss !== 4'd0) begin n_fail++; $display("FAIL clr_miss0: got %0d want 0", cnt_miss); end
        cnt_sel = 2'd1; #1;
        n_cmp++; if (cnt_hit !== 4'd1 || access_count !== 4'd1 || lat_sum !== 12'd11) begin n_fail++; $display("FAIL clr_inflight: got %0d/%0d/%0d want 1/1/11", cnt_hit, access_count, lat_sum); end
    endtask

    task automatic test_back_to_back();
        run_access(11'h030, 2'b11, 32'h31, 32'h32, 32'h33, 0, 0);
        n_cmp++; if (r_lat !== 3 || r_data !== 32'h31) begin n_fail++; $display("FAIL b2b_first: got %0d/%h want 3/31", r_lat, r_data); end
        run_access(11'h031, 2'b00, 32'h41, 32'h42, 32'h43, 0, 0);
        n_cmp++; if (r_lat !== 7 || r_data !== 32'h43 || r_level !== 3'd2) begin n_fail++; $display("FAIL b2b_second: got %0d/%h/%0d want 7/43/2", r_lat, r_data, r_level); end
    endtask

    initial begin
        test_reset();
        test_l1_hit();
        test_l2_hit();
        test_all_miss();
        test_backpressure();
        test_reset_in_fill();
        test_saturation();
        test_clear_coincide();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_hier_ctrl.md
# cache_hier_ctrl

Parametrised N-level cache hierarchy controller that replaces the fixed L1/L2 glue. It accepts one CPU request at a time over a valid/ready handshake and probes cache levels in order (L1 first). On a hit it promotes the data into every faster level; on a miss at all levels it fetches from main memory and fills all levels. It returns the data with the servicing level and keeps saturating per-level hit/miss counters plus a modeled-latency accumulator for AMAT.

## Interface
- ADDR_W, 11, request address width
- DATA_W, 32, data width
- LEVELS, 2, number of cache levels (1..4)
- CNT_W, 32, width of every performance counter
- LAT, {8'd100,8'd10,8'd1}, packed 8-bit modeled latencies; field i = level i, field LEVELS = main memory

- clk  in  1  clock; all logic on posedge
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller idle, request can be accepted
- req_addr  in  ADDR_W  request address
- lvl_lookup  out  LEVELS  one-hot probe strobe
- lvl_addr  out  ADDR_W  probe/fill address (latched req_addr)
- lvl_hit  in  LEVELS  per-level hit, sampled in CHECK
- lvl_data  in  LEVELS*DATA_W  per-level read data; level i at [i*DATA_W +: DATA_W]
- mem_data  in  DATA_W  main-memory read data for lvl_addr
- fill_en  out  LEVELS  per-level fill strobe
- fill_data  out  DATA_W  promotion data
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed
- resp_data  out  DATA_W  returned data
- resp_level  out  3  servicing level; LEVELS means memory
- clear_counters  in  1  synchronous zeroing of all counters
- cnt_sel  in  2  level select for the counter read port
- cnt_hit, cnt_miss  out  CNT_W  hit/miss counts of level cnt_sel; 0 if cnt_sel >= LEVELS
- access_count  out  CNT_W  completed accesses
- lat_sum  out  CNT_W+8  accumulated modeled latency

## Operation
- States: IDLE, PROBE(i), CHECK(i), MEM, FILL, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_addr and go to PROBE(0).
- PROBE(i): lvl_lookup[i]=1 for one cycle. Then CHECK(i).
- CHECK(i): sample lvl_hit[i]. On a hit: hit[i]++, capture lvl_data[i], set level k=i, then FILL if i>0, else RESP. On a miss: miss[i]++, then PROBE(i+1) if i<LEVELS-1, else MEM.
- MEM: capture mem_data, set k=LEVELS, then FILL.
- FILL: one cycle with fill_en[j]=1 for all j<k and fill_data equal to the captured data. Promotion is inclusive.
- RESP: resp_valid=1, with resp_data and resp_level held stable until resp_ready is high. Then IDLE.
- On RESP entry: access_count++, and lat_sum += LAT[0]+…+LAT[k].
- All counters saturate at all-ones and never wrap.
- clear_counters zeroes every counter that cycle. If an increment coincides with a clear, the clear wins. Later increments of an in-flight access still count.
- Only one transaction is outstanding at a time. req_valid is ignored outside IDLE.

## Timing
- Reset (rst_n=0 at a clock edge): state IDLE, all counters 0, every output 0 including req_ready. req_ready rises on the first edge with rst_n=1.
- Reset during any state abandons the transaction. No fill, no response; the next cycle is clean.
- Accept edge = E0. The counts below are cycles from E0 to the first resp_valid=1:
  - hit at level k: 2k+3 for k=0, 2k+4 for k>0;
  - memory: 2·LEVELS+3.
- Defaults: L1 hit 3, L2 hit 6, memory 7.
- lvl_lookup, fill_en and resp_valid are registered outputs. lvl_lookup and fill_en are never high together.
- After the resp handshake edge, the controller is in IDLE one cycle; the earliest next accept is the edge after that.
- LEVELS=1: no FILL is ever needed for a hit. A miss goes PROBE(0), CHECK(0), MEM, FILL, RESP.

## Test plan
- L1 hit, addr 0x012, lvl_hit=2'b01, L1 data 0xDEADBEEF -> resp_valid at E0+3, resp_data 0xDEADBEEF, resp_level 0, no fill_en, hit[0]=1, lat_sum=1.
- L2 hit, lvl_hit[0]=0, lvl_hit[1]=1, L2 data 0x12345678 -> lookup sequence 01 then 10, fill_en=01 with fill_data 0x12345678, resp at E0+6, resp_level 1, miss[0]=1, hit[1]=1, lat_sum=11.
- All miss, mem_data 0xCAFEF00D -> fill_en=11, resp_level 2, resp at E0+7, miss[0]=miss[1]=1, lat_sum=111.
- Backpressure: resp_ready low for 5 cycles -> resp_valid and resp_data stable, req_ready=0, access_count increments exactly once.
- Reset asserted during FILL -> no response; all counters read 0; req_ready=1 one edge after release.
- Force counters to all-ones minus 1, perform 3 L1 hits -> hit[0] saturates at all-ones. clear_counters pulsed in the same cycle as an increment -> counter reads 0.
